// File: rtl/opt_rr_scheduler.sv
// Round-robin scheduler granting one optical output port to one of
// P_CHANNEL_NUM requesters, with switch reconfiguration handshake,
// bounded hold time and a guard dead-time between grants.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset
//   i_req          per-channel request level
//   i_release      per-channel release (only the grantee's bit counts)
//   i_reconf_done  pulse: optical path settled (honoured in WAIT_CFG only)
//   o_grant        registered one-hot grant, zero when idle
//   o_grant_valid  grantee owns the settled path
//   o_reconf_start one-cycle pulse asking the configurator to switch
//   o_timeout      one-cycle pulse on a forced hold termination
//   o_busy         high in every state except IDLE
module opt_rr_scheduler #(
    parameter int unsigned P_CHANNEL_NUM  = 8,
    parameter int unsigned P_MAX_HOLD     = 256,
    parameter int unsigned P_GUARD_CYCLES = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [P_CHANNEL_NUM-1:0] i_req,
    input  logic [P_CHANNEL_NUM-1:0] i_release,
    input  logic                     i_reconf_done,
    output logic [P_CHANNEL_NUM-1:0] o_grant,
    output logic                     o_grant_valid,
    output logic                     o_reconf_start,
    output logic                     o_timeout,
    output logic                     o_busy
);

    localparam int unsigned N       = P_CHANNEL_NUM;
    localparam int unsigned HOLD_W  = (P_MAX_HOLD > 1) ? $clog2(P_MAX_HOLD) : 1;
    localparam int unsigned GUARD_W = (P_GUARD_CYCLES > 1) ? $clog2(P_GUARD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(P_MAX_HOLD - 1);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(P_GUARD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_WAIT_CFG,
        ST_HOLD,
        ST_GUARD
    } state_t;

    state_t              state_q, state_d;
    logic [N-1:0]        req_q, req_d;
    logic [N-1:0]        prio_q, prio_d;
    logic [N-1:0]        grant_q, grant_d;
    logic                valid_q, valid_d;
    logic                reconf_q, reconf_d;
    logic                timeout_q, timeout_d;
    logic                busy_q, busy_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [GUARD_W-1:0]  guard_q, guard_d;

    logic [2*N-1:0]      req_dbl;
    logic [2*N-1:0]      arb_dbl;
    logic [N-1:0]        arb_grant;
    logic [N-1:0]        grant_rot;
    logic                release_hit;
    logic                limit_hit;

    // Wrapping priority search: the subtraction clears the first request at
    // or above the pointer; the doubled vector supplies the wrap-around.
    assign req_dbl   = {req_q, req_q};
    assign arb_dbl   = req_dbl & ~(req_dbl - {{N{1'b0}}, prio_q});
    assign arb_grant = arb_dbl[N-1:0] | arb_dbl[2*N-1:N];

    // Next priority pointer: one above the channel just served.
    assign grant_rot = {grant_q[N-2:0], grant_q[N-1]};

    assign release_hit = |(i_release & grant_q);
    assign limit_hit   = (hold_q == HOLD_LAST);

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        prio_d    = prio_q;
        grant_d   = grant_q;
        valid_d   = valid_q;
        reconf_d  = 1'b0;
        timeout_d = 1'b0;
        hold_d    = hold_q;
        guard_d   = guard_q;

        unique case (state_q)
            ST_IDLE: begin
                if (|i_req) begin
                    req_d   = i_req;
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (|arb_grant) begin
                    grant_d  = arb_grant;
                    reconf_d = 1'b1;
                    state_d  = ST_WAIT_CFG;
                end else begin
                    // Unreachable with a captured non-zero request.
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_CFG: begin
                if (i_reconf_done) begin
                    valid_d = 1'b1;
                    hold_d  = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (release_hit || limit_hit) begin
                    // A release in the limit cycle wins over the timeout.
                    timeout_d = limit_hit & ~release_hit;
                    prio_d    = grant_rot;
                    grant_d   = '0;
                    valid_d   = 1'b0;
                    guard_d   = '0;
                    state_d   = ST_GUARD;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_GUARD: begin
                if (guard_q == GUARD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    guard_d = guard_q + GUARD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            prio_q    <= N'(1);
            grant_q   <= '0;
            valid_q   <= 1'b0;
            reconf_q  <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            hold_q    <= '0;
            guard_q   <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            prio_q    <= prio_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            reconf_q  <= reconf_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
            hold_q    <= hold_d;
            guard_q   <= guard_d;
        end
    end

    assign o_grant        = grant_q;
    assign o_grant_valid  = valid_q;
    assign o_reconf_start = reconf_q;
    assign o_timeout      = timeout_q;
    assign o_busy         = busy_q;

endmodule

// File: tb/tb_opt_rr_scheduler.sv
// Self-checking bench for opt_rr_scheduler (default parameters).
// Expected grants are queued when requests are driven and compared when
// o_reconf_start announces the DUT's choice.
module tb_opt_rr_scheduler;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [7:0] i_req;
    logic [7:0] i_release;
    logic       i_reconf_done;
    logic [7:0] o_grant;
    logic       o_grant_valid;
    logic       o_reconf_start;
    logic       o_timeout;
    logic       o_busy;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned timeout_seen = 0;
    logic [7:0]  exp_q[$];

    always #5 i_clk = ~i_clk;

    opt_rr_scheduler #(
        .P_CHANNEL_NUM (8),
        .P_MAX_HOLD    (256),
        .P_GUARD_CYCLES(16)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_req         (i_req),
        .i_release     (i_release),
        .i_reconf_done (i_reconf_done),
        .o_grant       (o_grant),
        .o_grant_valid (o_grant_valid),
        .o_reconf_start(o_reconf_start),
        .o_timeout     (o_timeout),
        .o_busy        (o_busy)
    );

    // Advance one clock; sample 1 time unit after the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
        if (o_timeout === 1'b1) timeout_seen++;
    endtask

    // Wait (bounded) for an o_reconf_start pulse and report the grant seen.
    task automatic wait_reconf(input int limit, output bit ok, output logic [7:0] g);
        ok = 1'b0;
        g  = '0;
        for (int i = 0; i < limit && !ok; i++) begin
            tick();
            if (o_reconf_start === 1'b1) begin
                ok = 1'b1;
                g  = o_grant;
            end
        end
    endtask

    task automatic pulse_done();
        i_reconf_done = 1'b1;
        tick();
        i_reconf_done = 1'b0;
    endtask

    task automatic apply_reset();
        i_rst_n       = 1'b0;
        i_req         = '0;
        i_release     = '0;
        i_reconf_done = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b1;
        timeout_seen = 0;
    endtask

    task automatic test_reset();
        i_rst_n       = 1'b0;
        i_req         = 8'hFF;
        i_release     = '0;
        i_reconf_done = 1'b0;
        tick();
        tick();
        n_checks++;
        if (o_grant !== 8'h00) $display("FAIL reset_grant: got %h expected 00", o_grant);
        else n_pass++;
        n_checks++;
        if ({o_grant_valid, o_reconf_start, o_timeout, o_busy} !== 4'b0000)
            $display("FAIL reset_flags: got %b expected 0000",
                     {o_grant_valid, o_reconf_start, o_timeout, o_busy});
        else n_pass++;
        i_req   = '0;
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_grant();
        bit ok;
        logic [7:0] g, e;
        apply_reset();
        i_req = 8'b1010_0000;
        exp_q.push_back(8'b0010_0000);
        wait_reconf(20, ok, g);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || g !== e) $display("FAIL basic_grant: got %h ok=%0d expected %h", g, ok, e);
        else n_pass++;
        i_req = '0;
        tick();
        tick();
        n_checks++;
        if ({o_reconf_start, o_grant_valid, o_grant} !== {2'b00, 8'h20})
            $display("FAIL basic_wait_cfg: got %b/%b/%h expected 0/0/20",
                     o_reconf_start, o_grant_valid, o_grant);
        else n_pass++;
        pulse_done();
        n_checks++;
        if (o_grant_valid !== 1'b1) $display("FAIL basic_valid: got %b expected 1", o_grant_valid);
        else n_pass++;
        i_release = 8'h20;
        tick();
        i_release = '0;
        n_checks++;
        if ({o_grant, o_grant_valid, o_busy, o_timeout} !== {8'h00, 3'b010})
            $display("FAIL basic_release: got %h/%b/%b/%b expected 00/0/1/0",
                     o_grant, o_grant_valid, o_busy, o_timeout);
        else n_pass++;
        repeat (15) tick();
        n_checks++;
        if (o_busy !== 1'b1) $display("FAIL basic_guard_busy: got %b expected 1", o_busy);
        else n_pass++;
        tick();
        n_checks++;
        if (o_busy !== 1'b0) $display("FAIL basic_guard_end: got %b expected 0", o_busy);
        else n_pass++;
    endtask

    task automatic test_fairness();
        bit ok;
        logic [7:0] g, e;
        apply_reset();
        i_req = 8'hFF;
        for (int k = 0; k < 9; k++) exp_q.push_back(8'(1 << (k % 8)));
        for (int k = 0; k < 9; k++) begin
            wait_reconf(40, ok, g);
            e = exp_q.pop_front();
            n_checks++;
            if (!ok || g !== e) $display("FAIL fair_grant_%0d: got %h ok=%0d expected %h", k, g, ok, e);
            else n_pass++;
            pulse_done();
            tick();
            tick();
            i_release = 8'hFF;
            tick();
            i_release = '0;
        end
        i_req = '0;
        n_checks++;
        if (timeout_seen != 0) $display("FAIL fair_no_timeout: got %0d pulses expected 0", timeout_seen);
        else n_pass++;
        repeat (20) tick();
    endtask

    task automatic test_prio_wrap();
        bit ok;
        logic [7:0] g, e;
        apply_reset();
        i_req = 8'h80;
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h80);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) i_req = 8'b1000_0001;
            wait_reconf(40, ok, g);
            e = exp_q.pop_front();
            n_checks++;
            if (!ok || g !== e) $display("FAIL wrap_grant_%0d: got %h ok=%0d expected %h", k, g, ok, e);
            else n_pass++;
            i_req = '0;
            pulse_done();
            i_release = g;
            tick();
            i_release = '0;
        end
        repeat (20) tick();
    endtask

    task automatic test_timeout();
        bit ok;
        bit found;
        int n;
        logic [7:0] g, e;
        apply_reset();
        i_req = 8'h04;
        exp_q.push_back(8'h04);
        wait_reconf(20, ok, g);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || g !== e) $display("FAIL tmo_grant: got %h ok=%0d expected %h", g, ok, e);
        else n_pass++;
        i_req = '0;
        pulse_done();
        timeout_seen = 0;
        found = 1'b0;
        n = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            n++;
            if (o_timeout === 1'b1) found = 1'b1;
        end
        n_checks++;
        if (!found || n != 256) $display("FAIL tmo_cycles: got %0d found=%0d expected 256", n, found);
        else n_pass++;
        n_checks++;
        if ({o_grant, o_grant_valid, o_busy} !== {8'h00, 2'b01})
            $display("FAIL tmo_exit: got %h/%b/%b expected 00/0/1", o_grant, o_grant_valid, o_busy);
        else n_pass++;
        tick();
        n_checks++;
        if (o_timeout !== 1'b0) $display("FAIL tmo_one_cycle: got %b expected 0", o_timeout);
        else n_pass++;
        repeat (14) tick();
        n_checks++;
        if (o_busy !== 1'b1) $display("FAIL tmo_guard_busy: got %b expected 1", o_busy);
        else n_pass++;
        tick();
        n_checks++;
        if (o_busy !== 1'b0 || timeout_seen != 1)
            $display("FAIL tmo_guard_end: got busy=%b pulses=%0d expected busy=0 pulses=1", o_busy, timeout_seen);
        else n_pass++;
    endtask

    task automatic test_release_filter();
        bit ok;
        logic [7:0] g, e;
        apply_reset();
        i_req = 8'h04;
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h04);
        wait_reconf(20, ok, g);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || g !== e) $display("FAIL rel_grant: got %h ok=%0d expected %h", g, ok, e);
        else n_pass++;
        i_req = '0;
        pulse_done();
        i_release = 8'h01;
        repeat (3) tick();
        n_checks++;
        if ({o_grant, o_grant_valid} !== {8'h04, 1'b1})
            $display("FAIL rel_ignored: got %h/%b expected 04/1", o_grant, o_grant_valid);
        else n_pass++;
        i_release = 8'hFF;
        tick();
        i_release = '0;
        n_checks++;
        if ({o_grant, o_timeout} !== {8'h00, 1'b0})
            $display("FAIL rel_all_ones: got %h/%b expected 00/0", o_grant, o_timeout);
        else n_pass++;
        repeat (16) tick();
        i_req = 8'h04;
        wait_reconf(20, ok, g);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || g !== e) $display("FAIL rel_regrant: got %h ok=%0d expected %h", g, ok, e);
        else n_pass++;
        i_req = '0;
        pulse_done();
        timeout_seen = 0;
        repeat (255) tick();
        n_checks++;
        if ({o_grant, o_grant_valid} !== {8'h04, 1'b1})
            $display("FAIL rel_before_limit: got %h/%b expected 04/1", o_grant, o_grant_valid);
        else n_pass++;
        i_release = 8'h04;
        tick();
        i_release = '0;
        tick();
        n_checks++;
        if (o_grant !== 8'h00 || timeout_seen != 0)
            $display("FAIL rel_at_limit: got %h pulses=%0d expected 00 pulses=0", o_grant, timeout_seen);
        else n_pass++;
        repeat (16) tick();
    endtask

    task automatic test_reset_mid_hold();
        bit ok;
        logic [7:0] g, e;
        apply_reset();
        i_req = 8'h08;
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h01);
        wait_reconf(20, ok, g);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || g !== e) $display("FAIL mid_grant_a: got %h ok=%0d expected %h", g, ok, e);
        else n_pass++;
        i_req = '0;
        pulse_done();
        i_release = 8'h08;
        tick();
        i_release = '0;
        repeat (16) tick();
        i_req = 8'h20;
        wait_reconf(20, ok, g);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || g !== e) $display("FAIL mid_grant_b: got %h ok=%0d expected %h", g, ok, e);
        else n_pass++;
        i_req = '0;
        pulse_done();
        repeat (5) tick();
        i_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_grant, o_grant_valid, o_busy} !== {8'h00, 2'b00})
            $display("FAIL mid_async_clear: got %h/%b/%b expected 00/0/0", o_grant, o_grant_valid, o_busy);
        else n_pass++;
        tick();
        tick();
        i_rst_n = 1'b1;
        i_req = 8'hFF;
        wait_reconf(20, ok, g);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || g !== e) $display("FAIL mid_after_reset: got %h ok=%0d expected %h", g, ok, e);
        else n_pass++;
        i_req = '0;
    endtask

    initial begin
        i_rst_n       = 1'b0;
        i_req         = '0;
        i_release     = '0;
        i_reconf_done = 1'b0;
        test_reset();
        test_basic_grant();
        test_fairness();
        test_prio_wrap();
        test_timeout();
        test_release_filter();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
